sfifo_rd_pipe: RTL and testbench

- Drain-side companion to the flop-based synchronous FIFOs. It pops words from a show-ahead FIFO using that FIFO's empty/dout/rd interface.
- It presents the words downstream as a registered valid/ready stream through a 2-entry output skid buffer.
- There is no combinational path from out_ready to fifo_rd. The block supports a synchronous flush and keeps transfer and drop statistics.

---
 rtl/sfifo_rd_pipe.sv | 127 ++++++++++++
 tb/tb_sfifo_rd_pipe.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sfifo_rd_pipe.sv
// Drain stage for show-ahead synchronous FIFOs: pops words into a 2-entry
// registered skid buffer and presents them as a valid/ready stream.
module sfifo_rd_pipe #(
    parameter int WIDTH     = 16,
    parameter int CNT_NBITS = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_dout,
    output logic                 fifo_rd,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    output logic [1:0]           level,
    output logic                 idle,
    output logic [CNT_NBITS-1:0] xfer_cnt,
    output logic [CNT_NBITS-1:0] drop_cnt
);
    // Handshake: a word moves on every rising edge with out_valid & out_ready;
    // while out_valid & ~out_ready the head word and out_valid hold steady.
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    logic [1:0]           occ_q, occ_d;
    logic [WIDTH-1:0]     ob0_q, ob0_d;
    logic [WIDTH-1:0]     ob1_q, ob1_d;
    logic [CNT_NBITS-1:0] xfer_cnt_q, xfer_cnt_d;
    logic [CNT_NBITS-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_NBITS:0]   drop_sum;
    logic                 push;
    logic                 pop;

    // fifo_rd depends only on registered occupancy, so out_ready never reaches it.
    assign fifo_rd   = rstn & ~fifo_empty & (flush | (occ_q != OCC_FULL));
    assign push      = fifo_rd & ~flush;
    assign out_valid = (occ_q != OCC_EMPTY) & ~flush;
    assign pop       = out_valid & out_ready;
    assign out_data  = ob0_q;
    assign level     = occ_q;
    assign idle      = fifo_empty & (occ_q == OCC_EMPTY) & ~flush;
    assign xfer_cnt  = xfer_cnt_q;
    assign drop_cnt  = drop_cnt_q;

    assign drop_sum = {1'b0, drop_cnt_q} + (CNT_NBITS+1)'(occ_q) + (CNT_NBITS+1)'(fifo_rd);

    always_comb begin
        occ_d      = occ_q;
        ob0_d      = ob0_q;
        ob1_d      = ob1_q;
        xfer_cnt_d = xfer_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (pop) begin
            xfer_cnt_d = xfer_cnt_q + CNT_NBITS'(1);
        end
        if (flush) begin
            occ_d      = OCC_EMPTY;
            drop_cnt_d = drop_sum[CNT_NBITS] ? '1 : drop_sum[CNT_NBITS-1:0];
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (push) begin
                        ob0_d = fifo_dout;
                        occ_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        ob0_d = fifo_dout;
                    end else if (push) begin
                        ob1_d = fifo_dout;
                        occ_d = OCC_FULL;
                    end else if (pop) begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        ob0_d = ob1_q;
                        occ_d = OCC_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            occ_q      <= OCC_EMPTY;
            ob0_q      <= '0;
            ob1_q      <= '0;
            xfer_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            occ_q      <= occ_d;
            ob0_q      <= ob0_d;
            ob1_q      <= ob1_d;
            xfer_cnt_q <= xfer_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Simulation-only diagnostics; stall_q remembers a held (valid, not ready) head.
    logic             stall_q, stall_d;
    logic [WIDTH-1:0] stall_data_q;

    assign stall_d = rstn & out_valid & ~out_ready;

    always_ff @(posedge clk) begin
        stall_q      <= stall_d;
        stall_data_q <= out_data;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (!(fifo_rd && fifo_empty))
                else $error("ERROR: fifo_rd asserted while fifo_empty");
            assert (!((occ_q == OCC_FULL) && push))
                else $error("ERROR: push into full output buffer");
            assert (!(stall_q && out_valid && (out_data != stall_data_q)))
                else $error("ERROR: out_data changed while stalled");
        end
    end
endmodule

// File: tb/tb_sfifo_rd_pipe.sv
// Bench for sfifo_rd_pipe: queue-based FIFO and output-buffer model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_sfifo_rd_pipe;
    localparam int W  = 16;
    localparam int CN = 16;
    localparam int CS = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          fifo_empty;
    logic [W-1:0]  fifo_dout;
    logic          flush;
    logic          out_ready;

    logic          fifo_rd, out_valid, idle;
    logic [W-1:0]  out_data;
    logic [1:0]    level;
    logic [CN-1:0] xfer_cnt, drop_cnt;

    logic          fifo_rd_s, out_valid_s, idle_s;
    logic [W-1:0]  out_data_s;
    logic [1:0]    level_s;
    logic [CS-1:0] xfer_cnt_s, drop_cnt_s;

    sfifo_rd_pipe #(.WIDTH(W), .CNT_NBITS(CN)) u_dut (
        .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd(fifo_rd), .flush(flush), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .level(level), .idle(idle),
        .xfer_cnt(xfer_cnt), .drop_cnt(drop_cnt)
    );

    // Narrow-counter instance shares all inputs so wrap/saturation edges are cheap to reach.
    sfifo_rd_pipe #(.WIDTH(W), .CNT_NBITS(CS)) u_dut_s (
        .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd(fifo_rd_s), .flush(flush), .out_valid(out_valid_s), .out_data(out_data_s),
        .out_ready(out_ready), .level(level_s), .idle(idle_s),
        .xfer_cnt(xfer_cnt_s), .drop_cnt(drop_cnt_s)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] env_q[$];   // contents of the attached FIFO
    logic [W-1:0] exp_q[$];   // words the block currently holds, head first
    int m_xfer = 0;
    int m_drop = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void refresh_env();
        fifo_empty = (env_q.size() == 0);
        fifo_dout  = (env_q.size() == 0) ? '0 : env_q[0];
    endfunction

    task automatic fill(input logic [W-1:0] base, input int n);
        for (int i = 0; i < n; i++) env_q.push_back(base + W'(i));
        refresh_env();
    endtask

    // One clock: compare at negedge against the model, then advance model and FIFO.
    task automatic step();
        int occ;
        bit e_rd, e_valid, rd_act;
        logic [W-1:0] head;
        @(negedge clk);
        occ     = exp_q.size();
        e_rd    = rstn && (env_q.size() != 0) && (flush || occ < 2);
        e_valid = (occ != 0) && !flush;
        chk("fifo_rd", fifo_rd, e_rd);
        chk("fifo_rd_s", fifo_rd_s, e_rd);
        chk("out_valid", out_valid, e_valid);
        chk("out_valid_s", out_valid_s, e_valid);
        if (e_valid) begin
            chk("out_data", out_data, exp_q[0]);
            chk("out_data_s", out_data_s, exp_q[0]);
        end
        chk("level", level, occ);
        chk("idle", idle, (env_q.size() == 0) && (occ == 0) && !flush);
        chk("xfer_cnt", xfer_cnt, m_xfer % (2**CN));
        chk("xfer_cnt_s", xfer_cnt_s, m_xfer % (2**CS));
        chk("drop_cnt", drop_cnt, (m_drop > 2**CN - 1) ? 2**CN - 1 : m_drop);
        chk("drop_cnt_s", drop_cnt_s, (m_drop > 2**CS - 1) ? 2**CS - 1 : m_drop);
        rd_act = fifo_rd;
        head   = fifo_dout;
        @(posedge clk);
        #1;
        if (!rstn) begin
            exp_q.delete();
            m_xfer = 0;
            m_drop = 0;
        end else begin
            if (rd_act && env_q.size() != 0) void'(env_q.pop_front());
            if (flush) begin
                m_drop += occ + int'(e_rd);
                exp_q.delete();
            end else begin
                if (e_valid && out_ready) begin
                    void'(exp_q.pop_front());
                    m_xfer++;
                end
                if (e_rd) exp_q.push_back(head);
            end
        end
        refresh_env();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        refresh_env();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_level", level, 0);
        chk("rst_xfer", xfer_cnt, 0);
        chk("rst_drop", drop_cnt, 0);

        // Words waiting while reset is held must not be popped.
        fill(16'h00A1, 2);
        step();
        rstn = 1'b1;
        step();
        chk("first_valid", out_valid, 1);
        chk("first_data", out_data, 16'h00A1);
        step();
        chk("first_level2", level, 2);
        out_ready = 1'b1;
        run(2);
        chk("first_xfer", xfer_cnt, 2);

        // Streaming at one word per clock.
        fill(16'h0100, 8);
        run(10);
        chk("stream_xfer", xfer_cnt, 10);
        chk("stream_drop", drop_cnt, 0);
        chk("stream_level", level, 0);

        // Backpressure: absorb two words, then stop reading.
        out_ready = 1'b0;
        env_q.push_back(16'h0011);
        env_q.push_back(16'h0022);
        env_q.push_back(16'h0033);
        refresh_env();
        run(4);
        chk("bp_level", level, 2);
        chk("bp_data", out_data, 16'h0011);
        chk("bp_rd", fifo_rd, 0);
        out_ready = 1'b1;
        run(3);
        chk("bp_xfer", xfer_cnt, 13);
        chk("bp_level0", level, 0);

        // Single-cycle flush with a full buffer and one FIFO word.
        out_ready = 1'b0;
        fill(16'h0041, 3);
        run(2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_drop", drop_cnt, 3);
        chk("flush_level", level, 0);
        chk("flush_xfer", xfer_cnt, 13);
        fill(16'h0044, 1);
        out_ready = 1'b1;
        run(3);
        chk("post_flush_xfer", xfer_cnt, 14);

        // Drop counter saturation on the narrow instance.
        flush = 1'b1;
        fill(16'h0200, 251);
        run(251);
        chk("drop_pre_sat", drop_cnt_s, 8'hFE);
        flush = 1'b0;
        out_ready = 1'b0;
        fill(16'h0300, 2);
        run(2);
        flush = 1'b1;
        step();
        chk("drop_sat_s", drop_cnt_s, 8'hFF);
        chk("drop_wide", drop_cnt, 16'h0100);
        fill(16'h0400, 1);
        step();
        chk("drop_hold_s", drop_cnt_s, 8'hFF);
        flush = 1'b0;

        // Transfer counter wrap on the narrow instance.
        out_ready = 1'b1;
        fill(16'h0500, 241);
        run(242);
        chk("xfer_pre_wrap_s", xfer_cnt_s, 8'hFF);
        chk("xfer_pre_wrap", xfer_cnt, 16'h00FF);
        fill(16'h0600, 1);
        run(2);
        chk("xfer_wrap_s", xfer_cnt_s, 8'h00);
        chk("xfer_wide", xfer_cnt, 16'h0100);

        // Reset mid-stream with a full buffer; the FIFO resets alongside.
        out_ready = 1'b0;
        fill(16'h0061, 3);
        run(2);
        rstn = 1'b0;
        step();
        env_q.delete();
        refresh_env();
        chk("mid_rst_level", level, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_xfer", xfer_cnt, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        rstn = 1'b1;
        out_ready = 1'b1;
        fill(16'h0071, 2);
        run(4);
        chk("resume_xfer", xfer_cnt, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
